rename_arbiter: RTL and testbench

- Shares the register file's single rename/operand-lookup port among NUM_REQ dispatch requesters: ALU RS, LSB, and the simple-instruction path (LUI/JAL-class).
- Arbitrates round-robin, drives one rename_need pulse per granted request, and waits for the register file's completion (rename_finish or simple_ins_commit with matching ROB id).
- Acks the requester and forwards the operand lookup results to it.
- Sits between the dispatch stage and the register file.

---
 rtl/rename_arbiter_pkg.sv | 18 +
 rtl/rename_arbiter_if.sv | 38 +++
 rtl/rename_arbiter_rr_picker.sv | 35 +++
 rtl/rename_arbiter.sv | 167 ++++++++++++++++
 tb/tb_rename_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_arbiter_pkg.sv
// Shared constants and types for the rename port arbiter.
package rename_arbiter_pkg;

    localparam int ROB_W  = 4;
    localparam int REG_W  = 5;
    localparam int KIND_W = 3;

    // Bit positions inside each requester's req_kind field
    localparam int KIND_SIMPLE = 2;
    localparam int KIND_BR_ST  = 1;
    localparam int KIND_RS2    = 0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/rename_arbiter_if.sv
// Dispatch-side bundle: per-requester rename requests and the shared ack/result bus.
interface rename_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ROB_W   = 4,
    parameter int REG_W   = 5
);
    import rename_arbiter_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ROB_W-1:0]  req_rob_id;
    logic [NUM_REQ*REG_W-1:0]  req_rd;
    logic [NUM_REQ*REG_W-1:0]  req_rs1;
    logic [NUM_REQ*REG_W-1:0]  req_rs2;
    logic [NUM_REQ*KIND_W-1:0] req_kind;

    logic [NUM_REQ-1:0]        req_ack;
    logic                      ack_op1_busy;
    logic                      ack_op2_busy;
    logic [ROB_W-1:0]          ack_op1_rename;
    logic [ROB_W-1:0]          ack_op2_rename;
    logic [31:0]               ack_op1_data;
    logic [31:0]               ack_op2_data;

    // Requesters (dispatch stage)
    modport master (
        output req_valid, req_rob_id, req_rd, req_rs1, req_rs2, req_kind,
        input  req_ack, ack_op1_busy, ack_op2_busy, ack_op1_rename, ack_op2_rename,
               ack_op1_data, ack_op2_data
    );

    // Arbiter
    modport slave (
        input  req_valid, req_rob_id, req_rd, req_rs1, req_rs2, req_kind,
        output req_ack, ack_op1_busy, ack_op2_busy, ack_op1_rename, ack_op2_rename,
               ack_op1_data, ack_op2_data
    );

endinterface

// File: rtl/rename_arbiter_rr_picker.sv
// Combinational round-robin pick: first eligible requester at or after ptr, wrapping.
module rename_arbiter_rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [NUM_REQ-1:0] exclude,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    // Scan NUM_REQ positions starting at ptr; keep the first eligible one
    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (!any && valid[idx] && !exclude[idx]) begin
                any       = 1'b1;
                grant_idx = idx;
            end
        end
    end

endmodule

// File: rtl/rename_arbiter.sv
// Shares the register file's rename/operand-lookup port among dispatch requesters.
module rename_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ROB_W   = rename_arbiter_pkg::ROB_W,
    parameter int REG_W   = rename_arbiter_pkg::REG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               flush,
    rename_arbiter_if.slave    disp,
    output logic               rename_need,
    output logic               rename_need_ins_is_simple,
    output logic               rename_need_ins_is_branch_or_store,
    output logic [ROB_W-1:0]   rename_need_id,
    output logic [ROB_W-1:0]   new_ins_rd_rename,
    output logic [REG_W-1:0]   new_ins_rd,
    output logic [REG_W-1:0]   operand_1_reg,
    output logic [REG_W-1:0]   operand_2_reg,
    output logic               operand_1_flag,
    output logic               operand_2_flag,
    input  logic               rename_finish,
    input  logic               simple_ins_commit,
    input  logic [ROB_W-1:0]   rename_finish_id,
    input  logic [ROB_W-1:0]   simple_ins_rename,
    input  logic               operand_1_busy,
    input  logic               operand_2_busy,
    input  logic [ROB_W-1:0]   operand_1_rename,
    input  logic [ROB_W-1:0]   operand_2_rename,
    input  logic [31:0]        operand_1_data_from_reg,
    input  logic [31:0]        operand_2_data_from_reg
);
    import rename_arbiter_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               do_grant, do_ack, done;
    logic [NUM_REQ-1:0] ack_vec;
    logic [ROB_W-1:0]   pick_id;
    logic [REG_W-1:0]   pick_rd, pick_rs1, pick_rs2;
    logic [KIND_W-1:0]  pick_kind;

    // The requester acked this cycle may still show req_valid; mask it out
    rename_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .valid     (disp.req_valid),
        .exclude   (disp.req_ack),
        .ptr       (rr_ptr),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // Select the picked requester's payload and build the one-hot ack vector
    always_comb begin
        pick_id   = '0;
        pick_rd   = '0;
        pick_rs1  = '0;
        pick_rs2  = '0;
        pick_kind = '0;
        ack_vec   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_id   = disp.req_rob_id[i*ROB_W +: ROB_W];
                pick_rd   = disp.req_rd[i*REG_W +: REG_W];
                pick_rs1  = disp.req_rs1[i*REG_W +: REG_W];
                pick_rs2  = disp.req_rs2[i*REG_W +: REG_W];
                pick_kind = disp.req_kind[i*KIND_W +: KIND_W];
            end
            ack_vec[i] = (grant_idx == IDX_W'(i));
        end
    end

    // Simple instructions complete via the commit path, all others via rename_finish
    assign done = rename_need_ins_is_simple
                ? (simple_ins_commit && (simple_ins_rename == rename_need_id))
                : (rename_finish && (rename_finish_id == rename_need_id));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else if (rdy) begin
            state <= state_nxt;
        end
    end

    // Next-state and grant/ack decisions; flush overrides both
    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        do_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any && !flush) begin
                    state_nxt = WAIT;
                    do_grant  = 1'b1;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (done) begin
                    state_nxt = IDLE;
                    do_ack    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Register-file request fields, ack pulse, forwarded results and rr pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rename_need                        <= 1'b0;
            rename_need_ins_is_simple          <= 1'b0;
            rename_need_ins_is_branch_or_store <= 1'b0;
            rename_need_id                     <= '0;
            new_ins_rd_rename                  <= '0;
            new_ins_rd                         <= '0;
            operand_1_reg                      <= '0;
            operand_2_reg                      <= '0;
            operand_1_flag                     <= 1'b0;
            operand_2_flag                     <= 1'b0;
            grant_idx                          <= '0;
            rr_ptr                             <= '0;
            disp.req_ack                       <= '0;
            disp.ack_op1_busy                  <= 1'b0;
            disp.ack_op2_busy                  <= 1'b0;
            disp.ack_op1_rename                <= '0;
            disp.ack_op2_rename                <= '0;
            disp.ack_op1_data                  <= '0;
            disp.ack_op2_data                  <= '0;
        end else if (rdy) begin
            rename_need  <= do_grant;
            disp.req_ack <= do_ack ? ack_vec : '0;
            if (do_grant) begin
                grant_idx                          <= pick_idx;
                rename_need_ins_is_simple          <= pick_kind[KIND_SIMPLE];
                rename_need_ins_is_branch_or_store <= pick_kind[KIND_BR_ST];
                rename_need_id                     <= pick_id;
                new_ins_rd_rename                  <= pick_id;
                new_ins_rd                         <= pick_rd;
                operand_1_reg                      <= pick_rs1;
                operand_2_reg                      <= pick_rs2;
                operand_1_flag                     <= !pick_kind[KIND_SIMPLE];
                operand_2_flag                     <= pick_kind[KIND_RS2] && !pick_kind[KIND_SIMPLE];
            end
            if (do_ack) begin
                disp.ack_op1_busy   <= operand_1_busy;
                disp.ack_op2_busy   <= operand_2_busy;
                disp.ack_op1_rename <= operand_1_rename;
                disp.ack_op2_rename <= operand_2_rename;
                disp.ack_op1_data   <= operand_1_data_from_reg;
                disp.ack_op2_data   <= operand_2_data_from_reg;
                rr_ptr <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rename_arbiter.sv
// Scoreboard bench for rename_arbiter: directed stimulus pushes expected grants/acks,
// a monitor pops and compares whenever the DUT raises rename_need or req_ack.
module tb_rename_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ROB_W   = 4;
    localparam int REG_W   = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic        rename_need, rename_need_ins_is_simple, rename_need_ins_is_branch_or_store;
    logic [3:0]  rename_need_id, new_ins_rd_rename;
    logic [4:0]  new_ins_rd, operand_1_reg, operand_2_reg;
    logic        operand_1_flag, operand_2_flag;
    logic        rename_finish = 1'b0, simple_ins_commit = 1'b0;
    logic [3:0]  rename_finish_id = '0, simple_ins_rename = '0;
    logic        operand_1_busy = 1'b0, operand_2_busy = 1'b0;
    logic [3:0]  operand_1_rename = '0, operand_2_rename = '0;
    logic [31:0] operand_1_data_from_reg = '0, operand_2_data_from_reg = '0;

    rename_arbiter_if #(.NUM_REQ(NUM_REQ), .ROB_W(ROB_W), .REG_W(REG_W)) disp ();

    rename_arbiter #(.NUM_REQ(NUM_REQ), .ROB_W(ROB_W), .REG_W(REG_W)) dut (
        .clk                                (clk),
        .rst                                (rst),
        .rdy                                (rdy),
        .flush                              (flush),
        .disp                               (disp),
        .rename_need                        (rename_need),
        .rename_need_ins_is_simple          (rename_need_ins_is_simple),
        .rename_need_ins_is_branch_or_store (rename_need_ins_is_branch_or_store),
        .rename_need_id                     (rename_need_id),
        .new_ins_rd_rename                  (new_ins_rd_rename),
        .new_ins_rd                         (new_ins_rd),
        .operand_1_reg                      (operand_1_reg),
        .operand_2_reg                      (operand_2_reg),
        .operand_1_flag                     (operand_1_flag),
        .operand_2_flag                     (operand_2_flag),
        .rename_finish                      (rename_finish),
        .simple_ins_commit                  (simple_ins_commit),
        .rename_finish_id                   (rename_finish_id),
        .simple_ins_rename                  (simple_ins_rename),
        .operand_1_busy                     (operand_1_busy),
        .operand_2_busy                     (operand_2_busy),
        .operand_1_rename                   (operand_1_rename),
        .operand_2_rename                   (operand_2_rename),
        .operand_1_data_from_reg            (operand_1_data_from_reg),
        .operand_2_data_from_reg            (operand_2_data_from_reg)
    );

    always #5 clk = ~clk;

    // flags = {is_simple, is_branch_or_store, operand_1_flag, operand_2_flag}
    typedef struct packed {
        logic [3:0] id;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [3:0] flags;
    } grant_t;

    // op = {busy, rename, data}
    typedef struct packed {
        logic [2:0]  vec;
        logic [36:0] op1;
        logic [36:0] op2;
    } ack_t;

    grant_t exp_grant[$];
    ack_t   exp_ack[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    logic   live     = 1'b0;
    logic   prev_need = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT output with no expected entry queued (t=%0t)", name, $time);
    endtask

    task automatic push_grant(input logic [3:0] id, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [3:0] flags);
        grant_t g;
        g.id = id; g.rd = rd; g.rs1 = rs1; g.rs2 = rs2; g.flags = flags;
        exp_grant.push_back(g);
    endtask

    task automatic push_ack(input logic [2:0] vec, input logic b1, input logic [3:0] r1,
                            input logic [31:0] d1, input logic b2, input logic [3:0] r2,
                            input logic [31:0] d2);
        ack_t a;
        a.vec = vec; a.op1 = {b1, r1, d1}; a.op2 = {b2, r2, d2};
        exp_ack.push_back(a);
    endtask

    task automatic set_req(input int i, input logic [3:0] id, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] kind);
        disp.req_rob_id[i*ROB_W +: ROB_W] = id;
        disp.req_rd[i*REG_W +: REG_W]     = rd;
        disp.req_rs1[i*REG_W +: REG_W]    = rs1;
        disp.req_rs2[i*REG_W +: REG_W]    = rs2;
        disp.req_kind[i*3 +: 3]           = kind;
        disp.req_valid[i]                 = 1'b1;
    endtask

    task automatic rf_resp(input logic fin, input logic com, input logic [3:0] id,
                           input logic b1, input logic [3:0] r1, input logic [31:0] d1,
                           input logic b2, input logic [3:0] r2, input logic [31:0] d2);
        rename_finish = fin; rename_finish_id = id;
        simple_ins_commit = com; simple_ins_rename = id;
        operand_1_busy = b1; operand_1_rename = r1; operand_1_data_from_reg = d1;
        operand_2_busy = b2; operand_2_rename = r2; operand_2_data_from_reg = d2;
    endtask

    task automatic rf_idle();
        rf_resp(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic wait_need(input string name);
        int n = 0;
        @(negedge clk);
        while (!rename_need && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, {63'd0, rename_need}, 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0; flush = 1'b0; rdy = 1'b1;
        disp.req_valid = '0;
        rf_idle();
        repeat (2) @(negedge clk);
        exp_grant.delete();
        exp_ack.delete();
        rst = 1'b1;
    endtask

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        live <= rdy && rst;
    end

    // Monitor: only outputs produced by an active (rdy high) edge are consumed
    always @(negedge clk) begin : monitor
        grant_t g;
        ack_t   a;
        if (live && rst) begin
            if (rename_need) begin
                check("need_single_pulse", {63'd0, prev_need}, 64'd0);
                if (exp_grant.size() == 0) begin
                    fail_now("unexpected_grant");
                end else begin
                    g = exp_grant.pop_front();
                    check("grant_id", {60'd0, rename_need_id}, {60'd0, g.id});
                    check("grant_rd_rename", {60'd0, new_ins_rd_rename}, {60'd0, g.id});
                    check("grant_regs", {49'd0, new_ins_rd, operand_1_reg, operand_2_reg},
                          {49'd0, g.rd, g.rs1, g.rs2});
                    check("grant_flags", {60'd0, rename_need_ins_is_simple,
                          rename_need_ins_is_branch_or_store, operand_1_flag, operand_2_flag},
                          {60'd0, g.flags});
                end
            end
            if (|disp.req_ack) begin
                if (exp_ack.size() == 0) begin
                    fail_now("unexpected_ack");
                end else begin
                    a = exp_ack.pop_front();
                    check("ack_vec", {61'd0, disp.req_ack}, {61'd0, a.vec});
                    check("ack_op1", {27'd0, disp.ack_op1_busy, disp.ack_op1_rename, disp.ack_op1_data},
                          {27'd0, a.op1});
                    check("ack_op2", {27'd0, disp.ack_op2_busy, disp.ack_op2_rename, disp.ack_op2_data},
                          {27'd0, a.op2});
                end
            end
            prev_need = rename_need;
        end else begin
            prev_need = 1'b0;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int          c0;
        int          order[4];
        logic [3:0]  ids[4];
        logic [2:0]  onehot;
        order = '{0, 1, 2, 0};
        ids   = '{4'd1, 4'd2, 4'd3, 4'd1};
        disp.req_valid = '0; disp.req_rob_id = '0; disp.req_rd = '0;
        disp.req_rs1 = '0; disp.req_rs2 = '0; disp.req_kind = '0;

        // Reset values
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_rf_side", {36'd0, rename_need, rename_need_ins_is_simple,
              rename_need_ins_is_branch_or_store, rename_need_id, new_ins_rd_rename, new_ins_rd,
              operand_1_reg, operand_2_reg, operand_1_flag, operand_2_flag}, 64'd0);
        check("reset_ack_side", {51'd0, disp.req_ack, disp.ack_op1_busy, disp.ack_op2_busy,
              disp.ack_op1_rename, disp.ack_op2_rename}, 64'd0);
        check("reset_ack_data", {disp.ack_op1_data, disp.ack_op2_data}, 64'd0);

        // Single request, minimum latency
        do_reset();
        c0 = cyc;
        set_req(0, 4'd5, 5'd3, 5'd1, 5'd2, 3'b001);
        push_grant(4'd5, 5'd3, 5'd1, 5'd2, 4'b0011);
        wait_need("t1_need");
        @(negedge clk);
        check("t1_need_once", {63'd0, rename_need}, 64'd0);
        push_ack(3'b001, 1'b0, 4'd0, 32'h10, 1'b1, 4'd7, 32'h0);
        rf_resp(1'b1, 1'b0, 4'd5, 1'b0, 4'd0, 32'h10, 1'b1, 4'd7, 32'h0);
        @(negedge clk);
        rf_idle();
        disp.req_valid = '0;
        check("t1_ack", {61'd0, disp.req_ack}, 64'b001);
        check("t1_latency", 64'(cyc - c0), 64'd3);
        @(negedge clk);
        check("t1_ack_pulse", {61'd0, disp.req_ack}, 64'd0);

        // Round-robin with all three requesting continuously
        do_reset();
        set_req(0, 4'd1, 5'd4, 5'd5, 5'd6, 3'b001);
        set_req(1, 4'd2, 5'd7, 5'd8, 5'd9, 3'b010);
        set_req(2, 4'd3, 5'd10, 5'd11, 5'd12, 3'b000);
        push_grant(4'd1, 5'd4, 5'd5, 5'd6, 4'b0011);
        push_grant(4'd2, 5'd7, 5'd8, 5'd9, 4'b0110);
        push_grant(4'd3, 5'd10, 5'd11, 5'd12, 4'b0010);
        push_grant(4'd1, 5'd4, 5'd5, 5'd6, 4'b0011);
        for (int k = 0; k < 4; k++) begin
            onehot = 3'(1 << order[k]);
            wait_need($sformatf("t2_need%0d", k));
            @(negedge clk);
            check("t2_no_need_in_wait", {63'd0, rename_need}, 64'd0);
            push_ack(onehot, k[0], 4'(k), 32'hA0 + 32'(k), 1'b0, 4'(k + 8), 32'hB0 + 32'(k));
            rf_resp(1'b1, 1'b0, ids[k], k[0], 4'(k), 32'hA0 + 32'(k), 1'b0, 4'(k + 8), 32'hB0 + 32'(k));
            @(negedge clk);
            rf_idle();
            if (k == 3) disp.req_valid = '0;
            check($sformatf("t2_ack%0d", k), {61'd0, disp.req_ack}, {61'd0, onehot});
        end

        // Simple instruction completes only via matching simple_ins_commit
        do_reset();
        set_req(2, 4'd9, 5'd6, 5'd7, 5'd8, 3'b100);
        push_grant(4'd9, 5'd6, 5'd7, 5'd8, 4'b1000);
        wait_need("t3_need");
        @(negedge clk);
        rf_resp(1'b1, 1'b0, 4'd9, 1'b0, 4'd0, 32'h1, 1'b0, 4'd0, 32'h2);
        @(negedge clk);
        check("t3_finish_ignored", {61'd0, disp.req_ack}, 64'd0);
        rf_resp(1'b0, 1'b1, 4'd8, 1'b0, 4'd0, 32'h3, 1'b0, 4'd0, 32'h4);
        @(negedge clk);
        check("t3_wrong_id_ignored", {61'd0, disp.req_ack}, 64'd0);
        push_ack(3'b100, 1'b1, 4'd3, 32'h1234, 1'b0, 4'd0, 32'h5678);
        rf_resp(1'b0, 1'b1, 4'd9, 1'b1, 4'd3, 32'h1234, 1'b0, 4'd0, 32'h5678);
        @(negedge clk);
        rf_idle();
        disp.req_valid = '0;
        check("t3_ack", {61'd0, disp.req_ack}, 64'b100);

        // Flush in WAIT beats a same-cycle completion; rr_ptr stays put
        do_reset();
        set_req(0, 4'd1, 5'd4, 5'd5, 5'd6, 3'b001);
        set_req(1, 4'd2, 5'd7, 5'd8, 5'd9, 3'b010);
        set_req(2, 4'd3, 5'd10, 5'd11, 5'd12, 3'b000);
        push_grant(4'd1, 5'd4, 5'd5, 5'd6, 4'b0011);
        push_grant(4'd1, 5'd4, 5'd5, 5'd6, 4'b0011);
        wait_need("t4_need");
        flush = 1'b1;
        rf_resp(1'b1, 1'b0, 4'd1, 1'b0, 4'd0, 32'hDEAD, 1'b0, 4'd0, 32'hDEAD);
        @(negedge clk);
        flush = 1'b0;
        rf_idle();
        check("t4_no_ack", {61'd0, disp.req_ack}, 64'd0);
        check("t4_need_low", {63'd0, rename_need}, 64'd0);
        wait_need("t4_regrant");
        @(negedge clk);
        push_ack(3'b001, 1'b0, 4'd2, 32'h44, 1'b0, 4'd3, 32'h55);
        rf_resp(1'b1, 1'b0, 4'd1, 1'b0, 4'd2, 32'h44, 1'b0, 4'd3, 32'h55);
        @(negedge clk);
        rf_idle();
        disp.req_valid = '0;
        check("t4_ack", {61'd0, disp.req_ack}, 64'b001);

        // rdy low for 5 cycles in WAIT with a matching response present
        do_reset();
        set_req(0, 4'd4, 5'd1, 5'd2, 5'd3, 3'b001);
        push_grant(4'd4, 5'd1, 5'd2, 5'd3, 4'b0011);
        wait_need("t5_need");
        @(negedge clk);
        rdy = 1'b0;
        rf_resp(1'b1, 1'b0, 4'd4, 1'b0, 4'd1, 32'hCAFE, 1'b0, 4'd2, 32'hBEEF);
        repeat (5) begin
            @(negedge clk);
            check("t5_stall_no_ack", {61'd0, disp.req_ack}, 64'd0);
            check("t5_hold_id", {60'd0, rename_need_id}, 64'd4);
        end
        rdy = 1'b1;
        rf_idle();
        @(negedge clk);
        check("t5_no_late_ack", {61'd0, disp.req_ack}, 64'd0);
        push_ack(3'b001, 1'b0, 4'd5, 32'h77, 1'b1, 4'd6, 32'h88);
        rf_resp(1'b1, 1'b0, 4'd4, 1'b0, 4'd5, 32'h77, 1'b1, 4'd6, 32'h88);
        @(negedge clk);
        rf_idle();
        disp.req_valid = '0;
        check("t5_ack", {61'd0, disp.req_ack}, 64'b001);

        // Async reset between edges while req1 is in WAIT; first grant afterwards is req0
        do_reset();
        set_req(0, 4'd1, 5'd4, 5'd5, 5'd6, 3'b001);
        set_req(1, 4'd2, 5'd7, 5'd8, 5'd9, 3'b010);
        set_req(2, 4'd3, 5'd10, 5'd11, 5'd12, 3'b000);
        push_grant(4'd1, 5'd4, 5'd5, 5'd6, 4'b0011);
        push_grant(4'd2, 5'd7, 5'd8, 5'd9, 4'b0110);
        wait_need("t6_need0");
        @(negedge clk);
        push_ack(3'b001, 1'b0, 4'd1, 32'h11, 1'b0, 4'd1, 32'h12);
        rf_resp(1'b1, 1'b0, 4'd1, 1'b0, 4'd1, 32'h11, 1'b0, 4'd1, 32'h12);
        @(negedge clk);
        rf_idle();
        check("t6_ack0", {61'd0, disp.req_ack}, 64'b001);
        wait_need("t6_need1");
        #2 rst = 1'b0;
        #1;
        check("t6_async_rf_side", {36'd0, rename_need, rename_need_ins_is_simple,
              rename_need_ins_is_branch_or_store, rename_need_id, new_ins_rd_rename, new_ins_rd,
              operand_1_reg, operand_2_reg, operand_1_flag, operand_2_flag}, 64'd0);
        check("t6_async_ack_data", {disp.ack_op1_data, disp.ack_op2_data}, 64'd0);
        @(negedge clk);
        exp_grant.delete();
        rst = 1'b1;
        push_grant(4'd1, 5'd4, 5'd5, 5'd6, 4'b0011);
        wait_need("t6_need_after_reset");
        @(negedge clk);
        push_ack(3'b001, 1'b1, 4'd9, 32'h99, 1'b1, 4'd10, 32'hAA);
        rf_resp(1'b1, 1'b0, 4'd1, 1'b1, 4'd9, 32'h99, 1'b1, 4'd10, 32'hAA);
        @(negedge clk);
        rf_idle();
        disp.req_valid = '0;
        check("t6_ack_after_reset", {61'd0, disp.req_ack}, 64'b001);

        repeat (3) @(negedge clk);
        check("grant_queue_drained", 64'(exp_grant.size()), 64'd0);
        check("ack_queue_drained", 64'(exp_ack.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
